key_sched_ctrl: RTL
===================

Name: key_sched_ctrl

Overview:
- Sequencer for the key-expansion / serialization path.
- On a start pulse it latches a 128-bit cipher key, then steps the key expander through round indices FIRST_RND..LAST_RND.
- For each round: waits for the expander's done, launches the parallel-to-serial byte unit, waits for its ready, and honours downstream backpressure before starting the next round.
- Sits between the top-level cipher control and the key_exp / pts_key pair; provides busy/done/error status and a watchdog.

Parameters:
- FIRST_RND, 0, first kcnt value issued (4 bits).
- LAST_RND, 10, last kcnt value issued; must satisfy LAST_RND >= FIRST_RND and LAST_RND <= 15.
- TMO, 64, maximum cycles spent in any wait state before error; the watchdog counter is clog2(TMO+1) bits wide.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a schedule; sampled only in IDLE.
- abort  in  1  synchronous abort; highest priority after rst.
- key  in  128  cipher key; captured on accepted start.
- cons_rdy  in  1  downstream can accept the next round's byte stream.
- kx_done  in  1  expander finished current round (level or pulse; first high cycle counts).
- pts_ready  in  1  serializer finished emitting 16 bytes (pulse).
- kx_en  out  1  one-cycle request to the expander.
- kx_kcnt  out  4  round index presented to the expander; stable from kx_en until kx_done.
- kx_key  out  128  latched key; held constant for the whole schedule.
- pts_start  out  1  one-cycle launch of the serializer.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- rnd  out  4  current round index (equals kx_kcnt).
- sched_done  out  1  one-cycle pulse after the last round is serialized.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset (rst=1 at clock edge):
  - State goes to IDLE.
  - kx_en=0, pts_start=0, sched_done=0, err=0, busy=0.
  - kx_kcnt=FIRST_RND, rnd=FIRST_RND, kx_key=0, watchdog=0.
- States: IDLE, EXP_REQ, EXP_WAIT, SER_START, SER_WAIT, GAP, DONE, ERR.
- IDLE:
  - start=1 latches key into kx_key, sets rnd=FIRST_RND, clears err, and goes to EXP_REQ.
  - start is ignored in every other state.
- EXP_REQ: kx_en=1 for exactly this one cycle; then go to EXP_WAIT.
- EXP_WAIT:
  - kx_done=1 goes to SER_START.
  - A kx_done seen in the EXP_REQ cycle itself is not accepted.
- SER_START: pts_start=1 for one cycle; then go to SER_WAIT.
- SER_WAIT:
  - If pts_ready=1 and rnd==LAST_RND, go to DONE.
  - If pts_ready=1 and rnd<LAST_RND, go to GAP.
- GAP: when cons_rdy=1, rnd increments by 1 and the state goes to EXP_REQ.
- DONE: sched_done=1 for one cycle; then go to IDLE.
  - Start-to-kx_en latency is therefore 1 cycle: start at cycle t gives kx_en at t+1.
- Watchdog:
  - Cleared on every state change.
  - Increments each cycle spent in EXP_WAIT or SER_WAIT. GAP is not timed, because backpressure is legal.
  - When the counter reaches TMO with no exit event: err=1 and go to ERR.
  - If the exit event and the limit coincide, the exit event wins.
- ERR:
  - busy=0, err held high.
  - start=1 clears err, relatches key, and goes to EXP_REQ, as in IDLE.
- abort=1 in any state:
  - Next state is IDLE; kx_en, pts_start and sched_done are forced 0 that cycle.
  - rnd returns to FIRST_RND. err and kx_key are unchanged.
  - abort and start in the same cycle: abort wins and start is dropped.
- rst mid-schedule behaves identically to power-up reset.
- rnd never wraps: the increment happens only when rnd<LAST_RND.
- FIRST_RND==LAST_RND is a legal configuration: a single round, then DONE.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Nominal: key=128'h2b7e151628aed2a6abf7158809cf4f3c, start at t0; expander model gives kx_done 3 cycles after kx_en; serializer model gives pts_ready 16 cycles after pts_start; cons_rdy=1 -> kx_en at t0+1 with kcnt=0, then 11 kx_en pulses with kcnt 0..10 in order; exactly 11 pts_start pulses; sched_done once after the 11th pts_ready; kx_key equals key throughout.
- Backpressure: cons_rdy=0 for 200 cycles after round 3 -> controller holds in GAP with rnd=3, no kx_en, err stays 0; kx_en with kcnt=4 occurs 1 cycle after cons_rdy rises.
- Timeout: expander model never asserts kx_done on round 5 -> err=1 exactly TMO=64 cycles after entering EXP_WAIT; busy=0; a following start restarts from kcnt=0 with err cleared.
- Abort mid-serialization: abort during SER_WAIT of round 7 -> next cycle IDLE, rnd=0, no sched_done; a late pts_ready is ignored; a new start gives kcnt=0.
- Simultaneous events: start+abort in the same cycle -> stays IDLE; pts_ready in the same cycle the watchdog hits 64 -> GAP taken, err=0.
- Reset: rst asserted during EXP_WAIT of round 2 -> next cycle all outputs at reset values, kx_key=0; start while busy is ignored (kx_key unchanged).

Source files
------------

// File: rtl/key_sched_ctrl.sv
// Round sequencer for the key expander / byte serializer pair.
// Steps kcnt FIRST_RND..LAST_RND with handshakes, backpressure and a wait-state watchdog.
module key_sched_ctrl #(
  parameter int FIRST_RND = 0,
  parameter int LAST_RND  = 10,
  parameter int TMO       = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key,
  input  logic         cons_rdy,
  input  logic         kx_done,
  input  logic         pts_ready,
  output logic         kx_en,
  output logic [3:0]   kx_kcnt,
  output logic [127:0] kx_key,
  output logic         pts_start,
  output logic         busy,
  output logic [3:0]   rnd,
  output logic         sched_done,
  output logic         err
);

  localparam int             WDW     = $clog2(TMO + 1);
  localparam logic [3:0]     FIRST   = 4'(FIRST_RND);
  localparam logic [3:0]     LAST    = 4'(LAST_RND);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXP_REQ, S_EXP_WAIT, S_SER_START, S_SER_WAIT, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [127:0]   key_q, key_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           kx_en_q, kx_en_d;
  logic           pts_start_q, pts_start_d;
  logic           sched_done_q, sched_done_d;
  logic           busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    key_d   = key_q;
    err_d   = err_q;
    wd_d    = wd_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          key_d   = key;
          rnd_d   = FIRST;
          err_d   = 1'b0;
          state_d = S_EXP_REQ;
        end
      end
      S_EXP_REQ:   state_d = S_EXP_WAIT;
      S_EXP_WAIT: begin
        if (kx_done) begin
          state_d = S_SER_START;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_SER_START: state_d = S_SER_WAIT;
      S_SER_WAIT: begin
        if (pts_ready) begin
          state_d = (rnd_q == LAST) ? S_DONE : S_GAP;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      // Backpressure may last arbitrarily long, so GAP is deliberately untimed.
      S_GAP: begin
        if (cons_rdy && (rnd_q < LAST)) begin
          rnd_d   = rnd_q + 4'd1;
          state_d = S_EXP_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      rnd_d   = FIRST;
      key_d   = key_q;
      err_d   = err_q;
    end

    if (state_d != state_q) wd_d = '0;

    // Strobes are decoded from the next state so they are high exactly while in that state.
    kx_en_d      = (state_d == S_EXP_REQ);
    pts_start_d  = (state_d == S_SER_START);
    sched_done_d = (state_d == S_DONE);
    busy_d       = !(state_d inside {S_IDLE, S_DONE, S_ERR});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rnd_q        <= FIRST;
      key_q        <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
      kx_en_q      <= 1'b0;
      pts_start_q  <= 1'b0;
      sched_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      key_q        <= key_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      kx_en_q      <= kx_en_d;
      pts_start_q  <= pts_start_d;
      sched_done_q <= sched_done_d;
      busy_q       <= busy_d;
    end
  end

  assign kx_en      = kx_en_q;
  assign kx_kcnt    = rnd_q;
  assign rnd        = rnd_q;
  assign kx_key     = key_q;
  assign pts_start  = pts_start_q;
  assign busy       = busy_q;
  assign sched_done = sched_done_q;
  assign err        = err_q;

endmodule
